// File: rtl/bubble_host_reader.sv
// Host-side bubble reader: drives the bubble control strobes and a bit clock,
// then captures one page of DIN lane samples into a page buffer write port.
module bubble_host_reader #(
    parameter int CLKDIV    = 12,
    parameter int BSS_SLOTS = 4,
    parameter int GAP_SLOTS = 2,
    parameter int PAGE_BITS = 512
) (
    input  logic        MCLK,
    input  logic        MRST,
    input  logic        REQ,
    input  logic        BOOTSEL,
    input  logic        BITWIDTH4,
    input  logic        DIN0,
    input  logic        DIN1,
    input  logic        DIN2,
    input  logic        DIN3,
    output logic        BCLK,
    output logic        nBSS,
    output logic        nBSEN,
    output logic        nREPEN,
    output logic        nBOOTEN,
    output logic        nSWAPEN,
    output logic        WREN,
    output logic [12:0] WRADDR,
    output logic [3:0]  WRDATA,
    output logic        BUSY,
    output logic        DONE
);

    localparam int SLOT_W  = $clog2(CLKDIV);
    localparam int SEG_MAX = (BSS_SLOTS > GAP_SLOTS) ? BSS_SLOTS : GAP_SLOTS;
    localparam int SEG_W   = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLKDIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(CLKDIV / 2);
    localparam logic [SLOT_W-1:0] SLOT_PRE  = SLOT_W'(CLKDIV / 2 - 1);
    localparam logic [SEG_W-1:0]  BSS_LAST  = SEG_W'(BSS_SLOTS - 1);
    localparam logic [SEG_W-1:0]  GAP_LAST  = SEG_W'(GAP_SLOTS - 1);
    localparam logic [12:0]       BIT_LAST  = 13'(PAGE_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        BSS,
        GAP,
        READ,
        TAIL,
        DONE_S
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [SLOT_W-1:0] slot_cnt;
    logic [SEG_W-1:0]  seg_cnt;
    logic [12:0]       bit_idx;
    logic              boot_q;
    logic              wide_q;
    logic              slot_end;
    logic              sample;

    assign slot_end = (slot_cnt == SLOT_LAST);
    // The write register loads on the edge that brings slot_cnt to mid-slot.
    assign sample   = (state == READ) && (slot_cnt == SLOT_PRE);
    assign nSWAPEN  = 1'b1;

    always_ff @(posedge MCLK) begin
        if (MRST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        nBSS     = 1'b1;
        nBSEN    = 1'b1;
        nREPEN   = 1'b1;
        nBOOTEN  = 1'b1;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        BCLK     = 1'b0;
        if (state != IDLE) begin
            BCLK = (slot_cnt < SLOT_HALF);
        end
        case (state)
            IDLE: begin
                if (REQ) begin
                    state_nx = BSS;
                end
            end
            BSS: begin
                nBSS    = 1'b0;
                nBOOTEN = ~boot_q;
                BUSY    = 1'b1;
                if (slot_end && (seg_cnt == BSS_LAST)) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                nBOOTEN = ~boot_q;
                BUSY    = 1'b1;
                if (slot_end && (seg_cnt == GAP_LAST)) begin
                    state_nx = READ;
                end
            end
            READ: begin
                nBSEN   = 1'b0;
                nREPEN  = 1'b0;
                nBOOTEN = ~boot_q;
                BUSY    = 1'b1;
                if (slot_end && (bit_idx == BIT_LAST)) begin
                    state_nx = TAIL;
                end
            end
            TAIL: begin
                BUSY = 1'b1;
                if (slot_end) begin
                    state_nx = DONE_S;
                end
            end
            DONE_S: begin
                DONE     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Slot, segment and bit counters; all held at zero while idle.
    always_ff @(posedge MCLK) begin
        if (MRST) begin
            slot_cnt <= '0;
            seg_cnt  <= '0;
            bit_idx  <= '0;
            boot_q   <= 1'b0;
            wide_q   <= 1'b0;
        end else if (state == IDLE) begin
            slot_cnt <= '0;
            seg_cnt  <= '0;
            bit_idx  <= '0;
            if (REQ) begin
                boot_q <= BOOTSEL;
                wide_q <= BITWIDTH4;
            end
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
            if (slot_end) begin
                case (state)
                    BSS:     seg_cnt <= (seg_cnt == BSS_LAST) ? '0 : seg_cnt + 1'b1;
                    GAP:     seg_cnt <= (seg_cnt == GAP_LAST) ? '0 : seg_cnt + 1'b1;
                    READ: begin
                        if (bit_idx != BIT_LAST) begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: seg_cnt <= seg_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (MRST) begin
            WREN   <= 1'b0;
            WRADDR <= '0;
            WRDATA <= '0;
        end else begin
            WREN <= sample;
            if (sample) begin
                WRADDR <= bit_idx;
                WRDATA <= wide_q ? {DIN3, DIN2, DIN1, DIN0} : {3'b000, DIN0};
            end
        end
    end

endmodule

// File: tb/tb_bubble_host_reader.sv
// Scoreboard bench for bubble_host_reader: default-parameter instance plus a
// CLKDIV=4 / PAGE_BITS=1 corner instance.
`timescale 1ns/1ps
module tb_bubble_host_reader;

    typedef struct {
        int         cyc;
        logic [12:0] addr;
        logic [3:0]  data;
    } wr_t;

    logic        MCLK = 1'b0;
    logic        MRST, REQ, req_s, BOOTSEL, BITWIDTH4;
    logic        DIN0, DIN1, DIN2, DIN3;
    logic        BCLK, nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN, WREN, BUSY, DONE;
    logic [12:0] WRADDR;
    logic [3:0]  WRDATA;
    logic        s_BCLK, s_nBSS, s_nBSEN, s_nREPEN, s_nBOOTEN, s_nSWAPEN, s_WREN, s_BUSY, s_DONE;
    logic [12:0] s_WRADDR;
    logic [3:0]  s_WRDATA;

    wr_t  exp_q[$];
    wr_t  exp_s_q[$];
    int   done_q[$];
    int   done_s_q[$];

    int ncyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int start_cyc = 0;
    int din_mode = 2;
    logic [3:0] din_const = 4'h0;
    int cnt_nbss, cnt_nbsen, cnt_nrepen, cnt_nbooten, cnt_nswapen, cnt_wren, done_cnt;
    int cnt_s_wren, done_s_cnt;

    bubble_host_reader u_dut (
        .MCLK(MCLK), .MRST(MRST), .REQ(REQ), .BOOTSEL(BOOTSEL), .BITWIDTH4(BITWIDTH4),
        .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2), .DIN3(DIN3),
        .BCLK(BCLK), .nBSS(nBSS), .nBSEN(nBSEN), .nREPEN(nREPEN), .nBOOTEN(nBOOTEN),
        .nSWAPEN(nSWAPEN), .WREN(WREN), .WRADDR(WRADDR), .WRDATA(WRDATA),
        .BUSY(BUSY), .DONE(DONE)
    );

    bubble_host_reader #(.CLKDIV(4), .BSS_SLOTS(4), .GAP_SLOTS(2), .PAGE_BITS(1)) u_small (
        .MCLK(MCLK), .MRST(MRST), .REQ(req_s), .BOOTSEL(BOOTSEL), .BITWIDTH4(BITWIDTH4),
        .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2), .DIN3(DIN3),
        .BCLK(s_BCLK), .nBSS(s_nBSS), .nBSEN(s_nBSEN), .nREPEN(s_nREPEN), .nBOOTEN(s_nBOOTEN),
        .nSWAPEN(s_nSWAPEN), .WREN(s_WREN), .WRADDR(s_WRADDR), .WRDATA(s_WRDATA),
        .BUSY(s_BUSY), .DONE(s_DONE)
    );

    initial forever #10 MCLK = ~MCLK;
    initial forever begin
        @(posedge MCLK);
        ncyc++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, ncyc);
        end
    endtask

    function automatic logic [3:0] laneVal(input int mode, input int k, input logic [3:0] cval);
        logic [3:0] v;
        v = cval;
        case (mode)
            0: v = {3'b111, ~k[0]};
            1: v = k[3:0];
            default: v = cval;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] expData(input int mode, input bit w4, input int k, input logic [3:0] cval);
        logic [3:0] v;
        v = laneVal(mode, k, cval);
        return w4 ? v : {3'b000, v[0]};
    endfunction

    // READ slot k of the default instance spans cycles 73+12k .. 84+12k after REQ.
    initial begin
        int rel;
        int k;
        forever begin
            @(negedge MCLK);
            rel = ncyc - start_cyc;
            k = (rel >= 73) ? (rel - 73) / 12 : 0;
            {DIN3, DIN2, DIN1, DIN0} = laneVal(din_mode, k, din_const);
        end
    end

    initial begin
        wr_t e;
        forever begin
            @(negedge MCLK);
            if (nBSS === 1'b0)    cnt_nbss++;
            if (nBSEN === 1'b0)   cnt_nbsen++;
            if (nREPEN === 1'b0)  cnt_nrepen++;
            if (nBOOTEN === 1'b0) cnt_nbooten++;
            if (nSWAPEN !== 1'b1) cnt_nswapen++;
            if (WREN === 1'b1) begin
                cnt_wren++;
                if (exp_q.size() == 0) begin
                    checkOutput("wren_pending", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", 32'(WRADDR), 32'(e.addr));
                    checkOutput("wr_data", 32'(WRDATA), 32'(e.data));
                    checkOutput("wr_cycle", ncyc, e.cyc);
                end
            end
            if (DONE === 1'b1) begin
                done_cnt++;
                checkOutput("busy_at_done", 32'(BUSY), 32'd0);
                if (done_q.size() == 0) checkOutput("done_pending", 32'(done_q.size()), 32'd1);
                else                    checkOutput("done_cycle", ncyc, done_q.pop_front());
            end
        end
    end

    initial begin
        wr_t e;
        forever begin
            @(negedge MCLK);
            if (s_WREN === 1'b1) begin
                cnt_s_wren++;
                if (exp_s_q.size() == 0) begin
                    checkOutput("s_wren_pending", 32'(exp_s_q.size()), 32'd1);
                end else begin
                    e = exp_s_q.pop_front();
                    checkOutput("s_wr_addr", 32'(s_WRADDR), 32'(e.addr));
                    checkOutput("s_wr_data", 32'(s_WRDATA), 32'(e.data));
                    checkOutput("s_wr_cycle", ncyc, e.cyc);
                end
            end
            if (s_DONE === 1'b1) begin
                done_s_cnt++;
                if (done_s_q.size() == 0) checkOutput("s_done_pending", 32'(done_s_q.size()), 32'd1);
                else                      checkOutput("s_done_cycle", ncyc, done_s_q.pop_front());
            end
        end
    end

    task automatic clearCounts();
        cnt_nbss = 0; cnt_nbsen = 0; cnt_nrepen = 0; cnt_nbooten = 0; cnt_nswapen = 0; cnt_wren = 0;
    endtask

    task automatic pushExpect(input int st, input bit w4, input int mode, input logic [3:0] cval);
        for (int k = 0; k < 512; k++) begin
            exp_q.push_back('{st + 79 + 12 * k, 13'(k), expData(mode, w4, k, cval)});
        end
        done_q.push_back(st + 6229);
    endtask

    task automatic applyStimulus(input bit boot, input bit w4, input int mode, input logic [3:0] cval, input bit hold);
        @(negedge MCLK);
        BOOTSEL = boot;
        BITWIDTH4 = w4;
        din_mode = mode;
        din_const = cval;
        start_cyc = ncyc;
        clearCounts();
        pushExpect(start_cyc, w4, mode, cval);
        REQ = 1'b1;
        @(negedge MCLK);
        if (!hold) REQ = 1'b0;
        checkOutput("nbss_fall", 32'(nBSS), 32'd0);
        checkOutput("busy_start", 32'(BUSY), 32'd1);
    endtask

    task automatic waitUntil(input int t);
        while (ncyc < t) @(negedge MCLK);
    endtask

    task automatic waitDone(input int bound);
        int target;
        int n;
        target = done_cnt + 1;
        n = 0;
        while (done_cnt < target && n < bound) begin
            @(negedge MCLK);
            n++;
        end
        checkOutput("done_seen", 32'(done_cnt >= target), 32'd1);
        @(negedge MCLK);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_nbss"},    32'(nBSS),    32'd1);
        checkOutput({tag, "_nbsen"},   32'(nBSEN),   32'd1);
        checkOutput({tag, "_nrepen"},  32'(nREPEN),  32'd1);
        checkOutput({tag, "_nbooten"}, 32'(nBOOTEN), 32'd1);
        checkOutput({tag, "_nswapen"}, 32'(nSWAPEN), 32'd1);
        checkOutput({tag, "_bclk"},    32'(BCLK),    32'd0);
        checkOutput({tag, "_busy"},    32'(BUSY),    32'd0);
        checkOutput({tag, "_done"},    32'(DONE),    32'd0);
        checkOutput({tag, "_wren"},    32'(WREN),    32'd0);
        checkOutput({tag, "_wraddr"},  32'(WRADDR),  32'd0);
        checkOutput({tag, "_wrdata"},  32'(WRDATA),  32'd0);
    endtask

    initial begin
        int st;
        int saved_done;
        MRST = 1'b1; REQ = 1'b0; req_s = 1'b0; BOOTSEL = 1'b0; BITWIDTH4 = 1'b0;
        clearCounts();
        done_cnt = 0; cnt_s_wren = 0; done_s_cnt = 0;

        // Reset then idle.
        repeat (4) @(posedge MCLK);
        @(negedge MCLK);
        checkIdleOutputs("reset");
        checkOutput("reset_s_busy", 32'(s_BUSY), 32'd0);
        MRST = 1'b0;
        clearCounts();
        repeat (1000) @(negedge MCLK);
        checkOutput("idle_wren_cnt", cnt_wren, 0);
        checkOutput("idle_busy", 32'(BUSY), 32'd0);

        // Default 1-bit read with DIN0 toggling per slot.
        $display("[TB] default 1-bit read");
        applyStimulus(1'b0, 1'b0, 0, 4'h0, 1'b0);
        waitDone(6400);
        checkOutput("rd1_nbss_low", cnt_nbss, 48);
        checkOutput("rd1_nbsen_low", cnt_nbsen, 6144);
        checkOutput("rd1_nrepen_low", cnt_nrepen, 6144);
        checkOutput("rd1_nbooten_low", cnt_nbooten, 0);
        checkOutput("rd1_nswapen", cnt_nswapen, 0);
        checkOutput("rd1_wren_cnt", cnt_wren, 512);

        // 4-lane boot read with DIN = slot index mod 16.
        $display("[TB] 4-lane boot read");
        applyStimulus(1'b1, 1'b1, 1, 4'h0, 1'b0);
        waitDone(6400);
        checkOutput("rd4_nbooten_low", cnt_nbooten, 6216);
        checkOutput("rd4_nbss_low", cnt_nbss, 48);
        checkOutput("rd4_wren_cnt", cnt_wren, 512);
        checkOutput("rd4_final_addr", 32'(WRADDR), 32'd511);

        // REQ while busy, then REQ held through DONE.
        $display("[TB] REQ while busy");
        applyStimulus(1'b0, 1'b1, 2, 4'hA, 1'b0);
        st = start_cyc;
        waitUntil(st + 100);  REQ = 1'b1; @(negedge MCLK); REQ = 1'b0;
        waitUntil(st + 3000); REQ = 1'b1; @(negedge MCLK); REQ = 1'b0;
        waitUntil(st + 6100); REQ = 1'b1;
        pushExpect(st + 6230, 1'b1, 2, 4'hA);
        waitDone(400);
        checkOutput("busy_single_wren", cnt_wren, 512);
        waitUntil(st + 6232);
        checkOutput("second_busy", 32'(BUSY), 32'd1);
        waitUntil(st + 6240);
        REQ = 1'b0;
        waitDone(6400);
        checkOutput("busy_total_wren", cnt_wren, 1024);

        // Reset while READ is at WRADDR 200.
        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 1'b0, 0, 4'h0, 1'b0);
        st = start_cyc;
        waitUntil(st + 79 + 12 * 200);
        MRST = 1'b1;
        @(negedge MCLK);
        exp_q.delete();
        done_q.delete();
        checkIdleOutputs("abort");
        saved_done = done_cnt;
        MRST = 1'b0;
        repeat (200) @(negedge MCLK);
        checkOutput("abort_no_done", done_cnt, saved_done);
        applyStimulus(1'b0, 1'b0, 0, 4'h0, 1'b0);
        waitDone(6400);
        checkOutput("restart_wren_cnt", cnt_wren, 512);

        // Parameter corner: CLKDIV = 4, PAGE_BITS = 1.
        $display("[TB] small-parameter corner");
        @(negedge MCLK);
        BITWIDTH4 = 1'b1;
        din_mode = 2;
        din_const = 4'h5;
        st = ncyc;
        exp_s_q.push_back('{st + 27, 13'd0, 4'h5});
        done_s_q.push_back(st + 33);
        req_s = 1'b1;
        @(negedge MCLK);
        req_s = 1'b0;
        repeat (60) @(negedge MCLK);
        checkOutput("s_wren_cnt", cnt_s_wren, 1);
        checkOutput("s_done_cnt", done_s_cnt, 1);
        checkOutput("s_busy_end", 32'(s_BUSY), 32'd0);

        checkOutput("exp_left", 32'(exp_q.size()), 32'd0);
        checkOutput("done_left", 32'(done_q.size()), 32'd0);
        checkOutput("s_exp_left", 32'(exp_s_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
